// File: rtl/bram_fifo_pkg.sv
// Shared geometry and helpers for the block-RAM backed FWFT FIFO.
// The RAM keeps one slot free, so it holds at most RAM_CAP words.
package bram_fifo_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 8;
  localparam int RAM_DEPTH = 1 << ADDR_W;
  localparam int RAM_CAP   = RAM_DEPTH - 1;
  localparam int STAGE_CAP = 2;
  localparam int CNT_W     = 9;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  // Number of words held in or heading for the output stage.
  function automatic logic [2:0] stage_occ(input logic head_full,
                                           input logic skid_full,
                                           input logic inflight);
    return {2'b00, head_full} + {2'b00, skid_full} + {2'b00, inflight};
  endfunction

endpackage

// File: rtl/bram_256x16.sv
// Simple dual-port block RAM, 256 x 16, registered read port.
// Read data appears on o_rdata the cycle after i_re.
module bram_256x16
  import bram_fifo_pkg::*;
(
  input  logic              i_wclk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_rclk,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [RAM_DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_wclk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge i_rclk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/bram_fifo.sv
// First-word-fall-through FIFO: 256x16 block RAM feeding a two-entry
// output stage (head + skid) so one push and one pop per cycle can be sustained.
module bram_fifo
  import bram_fifo_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_full,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_rdata,
  input  logic              i_rd,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_ovf,
  output logic              o_udf
);

  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic              r_inflight;
  logic              r_head_full;
  logic              r_skid_full;
  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_skid;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;
  logic              r_udf;

  logic [ADDR_W-1:0] w_ram_used;
  logic              w_ram_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_re;
  logic [2:0]        w_occ;
  logic [DATA_W-1:0] w_ram_rdata;

  assign w_ram_used  = r_wptr - r_rptr;
  assign w_ram_empty = (r_wptr == r_rptr);
  assign w_full      = (w_ram_used == ADDR_W'(RAM_CAP));

  assign w_push = i_wr & ~w_full & ~i_rst;
  assign w_pop  = i_rd & r_head_full & ~i_rst;

  // Fetch only if the word will have a place to land next cycle.
  assign w_occ = stage_occ(r_head_full, r_skid_full, r_inflight);
  assign w_re  = ~w_ram_empty & ~i_rst &
                 ((w_occ - {2'b00, w_pop}) < 3'(STAGE_CAP));

  bram_256x16 u_ram (
    .i_wclk  (i_clk),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata (i_wdata),
    .i_rclk  (i_clk),
    .i_re    (w_re),
    .i_raddr (r_rptr),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_inflight <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 8'd1;
      end
      if (w_re) begin
        r_rptr <= r_rptr + 8'd1;
      end
      r_inflight <= w_re;
    end
  end

  // Skid is only ever occupied behind a full head, which keeps order intact.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head_full <= 1'b0;
      r_skid_full <= 1'b0;
      r_head      <= '0;
      r_skid      <= '0;
    end else if (w_pop) begin
      if (r_skid_full) begin
        r_head <= r_skid;
        if (r_inflight) begin
          r_skid <= w_ram_rdata;
        end else begin
          r_skid_full <= 1'b0;
        end
      end else if (r_inflight) begin
        r_head <= w_ram_rdata;
      end else begin
        r_head_full <= 1'b0;
      end
    end else if (r_inflight) begin
      if (!r_head_full) begin
        r_head      <= w_ram_rdata;
        r_head_full <= 1'b1;
      end else begin
        r_skid      <= w_ram_rdata;
        r_skid_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 9'd1;
        2'b01:   r_count <= r_count - 9'd1;
        default: r_count <= r_count;
      endcase
      if (i_wr && w_full) begin
        r_ovf <= 1'b1;
      end
      if (i_rd && !r_head_full) begin
        r_udf <= 1'b1;
      end
    end
  end

  assign o_full  = w_full;
  assign o_valid = r_head_full;
  assign o_rdata = r_head;
  assign o_count = r_count;
  assign o_ovf   = r_ovf;
  assign o_udf   = r_udf;

endmodule

// File: tb/tb_bram_fifo.sv
// Directed + random bench for bram_fifo; the driver queues expected words,
// a negedge monitor pops them on every accepted read and tracks the count.
module tb_bram_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr;
  logic        rd;
  logic [15:0] wdata;
  logic        full;
  logic        valid;
  logic [15:0] rdata;
  logic [8:0]  count;
  logic        ovf;
  logic        udf;

  int          total = 0;
  int          bad   = 0;
  int          m_count = 0;
  bit          mon_en = 1'b0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  bram_fifo dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_wr    (wr),
    .i_wdata (wdata),
    .o_full  (full),
    .o_valid (valid),
    .o_rdata (rdata),
    .i_rd    (rd),
    .o_count (count),
    .o_ovf   (ovf),
    .o_udf   (udf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input bit w, input logic [15:0] d, input bit r);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    wr    = w;
    wdata = d;
    rd    = r;
    if (w && !full) exp_q.push_back(d);
  endtask

  task automatic cyc_pop();
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr  = 1'b0;
    rd  = valid;
  endtask

  task automatic do_reset(input bit busy);
    @(posedge clk);
    #1;
    rst   = 1'b1;
    wr    = busy;
    rd    = busy;
    wdata = 16'hAAAA;
    exp_q.delete();
  endtask

  task automatic drain(input string name);
    int budget = 600;
    while (exp_q.size() > 0 && budget > 0) begin
      cyc_pop();
      budget--;
    end
    if (budget == 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: words_left=%0d required=0", name, exp_q.size());
    end
    cyc(0, 16'h0, 0);
    cyc(0, 16'h0, 0);
    chk({name, "_count"}, 32'(count), 0);
    chk({name, "_valid"}, 32'(valid), 0);
  endtask

  // Monitor: checks count/flags every cycle and data on every accepted pop.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("count", 32'(count), 32'(m_count));
      if (m_count == 0)   chk("valid_when_empty", 32'(valid), 0);
      if (m_count < 255)  chk("full_low", 32'(full), 0);
      if (m_count == 257) chk("full_high", 32'(full), 1);
      if (rst) begin
        m_count = 0;
      end else begin
        if (rd && valid) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop_data: got=0x%0h expected=<queue empty>", rdata);
          end else begin
            chk("pop_data", 32'(rdata), 32'(exp_q.pop_front()));
          end
        end
        if (wr && !full)  m_count = m_count + 1;
        if (rd && valid)  m_count = m_count - 1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; wdata = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    do_reset(0);

    // Reset state
    cyc(0, 16'h0, 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_full",  32'(full),  0);
    chk("rst_ovf",   32'(ovf),   0);
    chk("rst_udf",   32'(udf),   0);

    // First-word latency: push in cycle 0, visible in cycle 3
    cyc(1, 16'h1234, 0);
    chk("lat_valid_c0", 32'(valid), 0);
    cyc(0, 16'h0, 0);
    chk("lat_count_c1", 32'(count), 1);
    chk("lat_valid_c1", 32'(valid), 0);
    cyc(0, 16'h0, 0);
    chk("lat_valid_c2", 32'(valid), 0);
    cyc(0, 16'h0, 0);
    chk("lat_valid_c3", 32'(valid), 1);
    chk("lat_rdata_c3", 32'(rdata), 32'h1234);
    cyc(0, 16'h0, 1);
    cyc(0, 16'h0, 0);
    chk("lat_count_after", 32'(count), 0);

    // Underflow on empty FIFO
    cyc(0, 16'h0, 1);
    cyc(0, 16'h0, 0);
    chk("udf_set",   32'(udf),   1);
    chk("udf_count", 32'(count), 0);
    chk("udf_valid", 32'(valid), 0);
    chk("udf_ovf",   32'(ovf),   0);
    do_reset(0);
    cyc(0, 16'h0, 0);
    chk("udf_cleared", 32'(udf), 0);

    // Fill to 257, then overflow
    for (int i = 0; i <= 256; i++) begin
      cyc(1, 16'(i), 0);
      chk("fill_not_full", 32'(full), 0);
    end
    cyc(0, 16'h0, 0);
    chk("fill_count", 32'(count), 257);
    chk("fill_full",  32'(full),  1);
    cyc(1, 16'hDEAD, 0);
    cyc(0, 16'h0, 0);
    chk("ovf_set",   32'(ovf),   1);
    chk("ovf_count", 32'(count), 257);
    drain("fill_drain");

    // Steady push+pop at 100 words, pointers wrap
    do_reset(0);
    for (int i = 0; i < 100; i++) cyc(1, 16'(i), 0);
    cyc(0, 16'h0, 0);
    cyc(0, 16'h0, 0);
    for (int i = 0; i < 600; i++) begin
      cyc(1, 16'(100 + i), 1);
      chk("stream_valid", 32'(valid), 1);
      chk("stream_count", 32'(count), 100);
    end
    drain("stream_drain");
    chk("stream_ovf", 32'(ovf), 0);
    chk("stream_udf", 32'(udf), 0);

    // Reset with a read in flight and 10 words held
    do_reset(0);
    for (int i = 0; i < 11; i++) cyc(1, 16'(16'h0100 + i), 0);
    repeat (3) cyc(0, 16'h0, 0);
    cyc(0, 16'h0, 1);
    do_reset(1);
    chk("midrst_pre_count", 32'(count), 10);
    cyc(0, 16'h0, 0);
    chk("midrst_valid", 32'(valid), 0);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_full",  32'(full),  0);
    cyc(0, 16'h0, 0);
    chk("midrst_valid_late", 32'(valid), 0);
    cyc(1, 16'hBEEF, 0);
    repeat (3) cyc(0, 16'h0, 0);
    chk("midrst_beef_rdata", 32'(rdata), 32'hBEEF);
    drain("midrst_drain");

    // Random traffic against the reference queue
    do_reset(0);
    for (int i = 0; i < 10000; i++) begin
      cyc(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
    end
    drain("rand_drain");

    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
